// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide controller for the E stage: fixed-latency mult/div with HI/LO commit.
// Optional MDU_CANCEL_EN adds a Cancel input that aborts an in-flight operation.
module mdu_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
`ifdef MDU_CANCEL_EN
  input  logic        Cancel,
`endif
  input  logic        Start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic        BusyOrStart,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        pend_hi, pend_lo;
  logic               cancel;
  logic               is_mul, is_div;
  logic [63:0]        prod;
  logic [31:0]        a_mag, b_mag, uq, ur, dq, dr;

`ifdef MDU_CANCEL_EN
  assign cancel = Cancel;
`else
  assign cancel = 1'b0;
`endif

  assign is_mul      = (MDOp == 3'd1) || (MDOp == 3'd2);
  assign is_div      = (MDOp == 3'd3) || (MDOp == 3'd4);
  assign BusyOrStart = Busy | (Start & (is_mul | is_div));

  // Operand-side arithmetic, captured into pending regs when an op is accepted.
  always_comb begin
    if (MDOp == 3'd1)
      prod = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    else
      prod = {32'd0, A} * {32'd0, B};

    a_mag = A[31] ? 32'(-A) : A;
    b_mag = B[31] ? 32'(-B) : B;
    uq    = '0;
    ur    = '0;
    dq    = LO;
    dr    = HI;
    if (B != 32'd0) begin
      if (MDOp == 3'd3) begin
        // Magnitude divide, then restore signs: quotient truncates, remainder follows dividend.
        uq = a_mag / b_mag;
        ur = a_mag % b_mag;
        dq = (A[31] ^ B[31]) ? 32'(-uq) : uq;
        dr = A[31] ? 32'(-ur) : ur;
      end else begin
        uq = A / B;
        ur = A % B;
        dq = uq;
        dr = ur;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      Busy    <= 1'b0;
      HI      <= '0;
      LO      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!cancel) begin
            if (Start && is_mul) begin
              pend_hi <= prod[63:32];
              pend_lo <= prod[31:0];
              cnt     <= CNT_W'(MULT_CYCLES - 1);
              state   <= MUL;
              Busy    <= 1'b1;
            end else if (Start && is_div) begin
              pend_hi <= dr;
              pend_lo <= dq;
              cnt     <= CNT_W'(DIV_CYCLES - 1);
              state   <= DIV;
              Busy    <= 1'b1;
            end else if (MDOp == 3'd5) begin
              HI <= A;
            end else if (MDOp == 3'd6) begin
              LO <= A;
            end
          end
        end
        MUL, DIV: begin
          // Cancel wins over completion; new requests are ignored while busy.
          if (cancel) begin
            state <= IDLE;
            Busy  <= 1'b0;
          end else if (cnt == '0) begin
            HI    <= pend_hi;
            LO    <= pend_lo;
            state <= IDLE;
            Busy  <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: expected HI/LO and busy length queued at issue, checked when Busy drops.
module tb_mdu_ctrl;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        Start = 1'b0;
  logic [2:0]  MDOp = 3'd0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        Busy, BusyOrStart;
  logic [31:0] HI, LO;
`ifdef MDU_CANCEL_EN
  logic        Cancel = 1'b0;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  exp_t        sb[$];
  int unsigned busy_cnt = 0;
  logic        prev_busy = 1'b0;

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk),
    .reset(reset),
`ifdef MDU_CANCEL_EN
    .Cancel(Cancel),
`endif
    .Start(Start),
    .MDOp(MDOp),
    .A(A),
    .B(B),
    .Busy(Busy),
    .BusyOrStart(BusyOrStart),
    .HI(HI),
    .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a completed (or cancelled) operation shows up as Busy falling.
  always @(negedge clk) begin
    if (!reset) begin
      busy_cnt = 0;
    end else if (Busy) begin
      busy_cnt++;
    end else if (prev_busy) begin
      if (sb.size() == 0) begin
        check("unexpected_completion", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("hi", HI, e.hi);
        check("lo", LO, e.lo);
        check("busy_cycles", busy_cnt, e.cyc);
      end
      busy_cnt = 0;
    end
    prev_busy = Busy & reset;
  end

  // One-cycle request; BusyOrStart checked in the request cycle.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic st, input logic bos);
    @(posedge clk); #1;
    Start = st; MDOp = op; A = a; B = b;
    @(negedge clk);
    check("busy_or_start", 32'(BusyOrStart), 32'(bos));
    @(posedge clk); #1;
    Start = 1'b0; MDOp = 3'd0;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!Busy) begin
        done = 1;
        break;
      end
    end
    check("idle_timeout", 32'(done), 32'd1);
  endtask

  function automatic exp_t mk(input logic [31:0] hi, input logic [31:0] lo, input logic [31:0] c);
    exp_t e;
    e.hi = hi; e.lo = lo; e.cyc = c;
    return e;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    #12;
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_bos", 32'(BusyOrStart), 32'd0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // mthi / mtlo
    issue(3'd5, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
    check("mthi_busy", 32'(Busy), 32'd0);
    check("mthi_hi", HI, 32'h1234_5678);
    MDOp = 3'd6; A = 32'h9ABC_DEF0;
    @(negedge clk);
    check("mtlo_bos", 32'(BusyOrStart), 32'd0);
    @(posedge clk); #1;
    MDOp = 3'd0;
    @(negedge clk);
    check("mtlo_busy", 32'(Busy), 32'd0);
    check("mt_hi", HI, 32'h1234_5678);
    check("mt_lo", LO, 32'h9ABC_DEF0);

    // mult -2 * 3; HI/LO stay old during Busy
    sb.push_back(mk(32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'd5));
    issue(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b1, 1'b1);
    @(negedge clk);
    check("mult_busy", 32'(Busy), 32'd1);
    check("mult_old_hi", HI, 32'h1234_5678);
    check("mult_old_lo", LO, 32'h9ABC_DEF0);
    wait_idle();

    // multu max * max
    sb.push_back(mk(32'hFFFF_FFFE, 32'h0000_0001, 32'd5));
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
    wait_idle();

    // div -7 / 2, then divide by zero keeps HI/LO
    sb.push_back(mk(32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd10));
    issue(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1);
    wait_idle();
    sb.push_back(mk(32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd10));
    issue(3'd3, 32'h0000_0123, 32'd0, 1'b1, 1'b1);
    wait_idle();

    // Signed overflow
    sb.push_back(mk(32'h0000_0000, 32'h8000_0000, 32'd10));
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1);
    wait_idle();

    // Reserved op with Start is ignored
    issue(3'd7, 32'd5, 32'd5, 1'b1, 1'b0);
    check("op7_busy", 32'(Busy), 32'd0);

    // divu interrupted by reset at Busy cycle 4
    issue(3'd4, 32'd100, 32'd7, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("arst_busy", 32'(Busy), 32'd0);
    check("arst_hi", HI, 32'd0);
    check("arst_lo", LO, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    sb.push_back(mk(32'd2, 32'd14, 32'd10));
    issue(3'd4, 32'd100, 32'd7, 1'b1, 1'b1);
    wait_idle();

    // Start/mthi while busy are ignored; div commits at t+11
    sb.push_back(mk(32'd2, 32'hFFFF_FFF2, 32'd10));
    issue(3'd3, 32'd100, 32'hFFFF_FFF9, 1'b1, 1'b1);
    @(posedge clk); #1;
    Start = 1'b1; MDOp = 3'd1; A = 32'd5; B = 32'd5;
    @(negedge clk);
    check("busy_start_bos", 32'(BusyOrStart), 32'd1);
    @(posedge clk); #1;
    Start = 1'b0; MDOp = 3'd5; A = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    MDOp = 3'd0;
    wait_idle();
    @(negedge clk);
    check("no_second_op", 32'(Busy), 32'd0);

`ifdef MDU_CANCEL_EN
    // Cancel at Busy cycle 3: HI/LO unchanged
    sb.push_back(mk(32'd2, 32'hFFFF_FFF2, 32'd3));
    issue(3'd1, 32'd6, 32'd7, 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    Cancel = 1'b1;
    @(posedge clk); #1;
    Cancel = 1'b0;
    @(negedge clk);
    check("cancel_busy", 32'(Busy), 32'd0);
    // Cancel with Start in IDLE, and Cancel blocking mtlo
    Cancel = 1'b1;
    issue(3'd3, 32'd9, 32'd3, 1'b1, 1'b1);
    check("cancel_start_busy", 32'(Busy), 32'd0);
    issue(3'd6, 32'h5555_5555, 32'd0, 1'b0, 1'b0);
    Cancel = 1'b0;
    check("cancel_mtlo", LO, 32'hFFFF_FFF2);
`endif

    repeat (2) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
